uart_rx: RTL and testbench

- 8N1 UART receiver; the receive-side counterpart of the project's TxD/TxD_busy serial transmitter.
- Samples the asynchronous RxD line at 16x the baud rate and validates the start bit at mid-bit.
- Delivers each received byte with a one-clock ready strobe and flags framing errors.
- Sits between the board RX pin and the micro/ROM control logic on the 50 MHz system clock.

---
 rtl/uart_rx.sv | 173 +++++++++++++++++
 tb/tb_uart_rx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling and mid-bit start validation.
// Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD selects odd/even) and the parity_err strobe.
module uart_rx #(
   parameter int CLK_FREQ = 50000000,
   parameter int BAUD     = 115200
`ifdef UART_RX_PARITY_EN
   ,
   parameter bit PARITY_ODD = 1'b0
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       RxD,
   output logic [7:0] RxD_data,
   output logic       RxD_data_ready,
   output logic       RxD_busy,
   output logic       framing_err,
   output logic       parity_err
);

   localparam int TICK_DIV = CLK_FREQ / (BAUD * 16);
   localparam int TW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd4;
`endif

   logic          sync1;
   logic          sync2;
   logic          sync3;
   logic          rx_s;
   logic          fall;
   logic [TW-1:0] tick_cnt;
   logic          tick;
   logic [3:0]    os_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift_reg;
   logic [2:0]    state;
`ifdef UART_RX_PARITY_EN
   logic          par_bit;
   logic          par_bad;
`endif

   // Preset to idle-high so leaving reset never looks like a start edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         sync3 <= 1'b1;
      end else begin
         sync1 <= RxD;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign rx_s = sync2;
   assign fall = sync3 & ~sync2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_cnt <= '0;
      end else if (state == S_IDLE || tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + TW'(1);
      end
   end

   assign tick     = (tick_cnt == TICK_MAX);
   assign RxD_busy = (state != S_IDLE);

`ifdef UART_RX_PARITY_EN
   assign par_bad = ((^shift_reg) ^ par_bit) != PARITY_ODD;
`else
   assign parity_err = 1'b0;
`endif

   // Sampling points: count 7 of the start bit, count 15 of every later bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= S_IDLE;
         os_cnt         <= 4'd0;
         bit_cnt        <= 3'd0;
         shift_reg      <= 8'h00;
         RxD_data       <= 8'h00;
         RxD_data_ready <= 1'b0;
         framing_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err     <= 1'b0;
         par_bit        <= 1'b0;
`endif
      end else begin
         RxD_data_ready <= 1'b0;
         framing_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err     <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               os_cnt  <= 4'd0;
               bit_cnt <= 3'd0;
               if (fall) state <= S_START;
            end
            S_START: begin
               if (tick) begin
                  if (os_cnt == 4'd7) begin
                     os_cnt <= 4'd0;
                     state  <= rx_s ? S_IDLE : S_DATA;
                  end else begin
                     os_cnt <= os_cnt + 4'd1;
                  end
               end
            end
            S_DATA: begin
               if (tick) begin
                  os_cnt <= os_cnt + 4'd1;
                  if (os_cnt == 4'd15) begin
                     shift_reg <= {rx_s, shift_reg[7:1]};
                     bit_cnt   <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state <= S_PARITY;
`else
                        state <= S_STOP;
`endif
                     end
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (tick) begin
                  os_cnt <= os_cnt + 4'd1;
                  if (os_cnt == 4'd15) begin
                     par_bit <= rx_s;
                     state   <= S_STOP;
                  end
               end
            end
`endif
            // Leave at mid stop bit so a back-to-back start edge is not missed.
            S_STOP: begin
               if (tick) begin
                  os_cnt <= os_cnt + 4'd1;
                  if (os_cnt == 4'd15) begin
                     state <= S_IDLE;
                     if (!rx_s) begin
                        framing_err <= 1'b1;
                     end
`ifdef UART_RX_PARITY_EN
                     else if (par_bad) begin
                        parity_err <= 1'b1;
                     end
`endif
                     else begin
                        RxD_data       <= shift_reg;
                        RxD_data_ready <= 1'b1;
                     end
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed and random frames checked against a frame-level model.
module tb_uart_rx;

   localparam int K_READY = 1;
   localparam int K_FERR  = 2;
   localparam int K_PERR  = 3;
`ifdef UART_RX_PARITY_EN
   localparam int EXP_LAT = 1683;
`else
   localparam int EXP_LAT = 1523;
`endif

   typedef struct {
      logic [7:0] data;
      bit         stop;
      bit         par_flip;
      int         bit_clks;
      int         gap;
      int         exp_kind;
      logic [7:0] exp_data;
   } vec_t;

   typedef struct {
      int         kind;
      logic [7:0] data;
      int         cyc;
   } event_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       RxD;
   logic [7:0] RxD_data;
   logic       RxD_data_ready;
   logic       RxD_busy;
   logic       framing_err;
   logic       parity_err;

   int     cyc = 0;
   int     n_vec = 0;
   int     n_miss = 0;
   bit     prev_any = 1'b0;
   event_t ev_q[$];

   uart_rx #(.CLK_FREQ(50000000), .BAUD(312500)) dut (
      .clk(clk),
      .rst(rst),
      .RxD(RxD),
      .RxD_data(RxD_data),
      .RxD_data_ready(RxD_data_ready),
      .RxD_busy(RxD_busy),
      .framing_err(framing_err),
      .parity_err(parity_err)
   );

   always #10 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_vec++;
      if (actual !== expected) begin
         n_miss++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Records every strobe and checks exclusivity and single-cycle width.
   always begin : monitor
      int     hits;
      event_t e;
      @(posedge clk);
      #5;
      hits = int'(RxD_data_ready) + int'(framing_err) + int'(parity_err);
      if (hits != 0) begin
         checkOutput("strobe_onehot", hits, 1);
         checkOutput("strobe_width", int'(prev_any), 0);
         e.kind = RxD_data_ready ? K_READY : (framing_err ? K_FERR : K_PERR);
         e.data = RxD_data;
         e.cyc  = cyc;
         ev_q.push_back(e);
      end
      prev_any = (hits != 0);
   end

   task automatic holdLine(input logic v, input int n);
      RxD = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic sendFrame(input vec_t v, output int start_cyc);
      int bc;
      bc = v.bit_clks;
      start_cyc = cyc;
      holdLine(1'b0, bc);
      for (int i = 0; i < 8; i++) begin
         if (i == 4) begin
            holdLine(v.data[i], bc / 2);
            checkOutput("busy_mid_frame", int'(RxD_busy), 1);
            holdLine(v.data[i], bc - bc / 2);
         end else begin
            holdLine(v.data[i], bc);
         end
      end
`ifdef UART_RX_PARITY_EN
      holdLine((^v.data) ^ v.par_flip, bc);
`endif
      holdLine(v.stop, bc);
      if (v.gap > 0) holdLine(1'b1, v.gap);
   endtask

   task automatic applyStimulus(input vec_t v);
      int start_cyc;
      int lat;
      ev_q.delete();
      sendFrame(v, start_cyc);
      checkOutput("event_count", ev_q.size(), 1);
      if (ev_q.size() > 0) begin
         checkOutput("event_kind", ev_q[0].kind, v.exp_kind);
         if (v.bit_clks == 160) begin
            lat = ev_q[0].cyc - start_cyc;
            checkOutput("latency", (lat >= EXP_LAT - 1 && lat <= EXP_LAT + 1) ? EXP_LAT : lat, EXP_LAT);
         end
      end
      checkOutput("rxd_data", int'(RxD_data), int'(v.exp_data));
   endtask

   initial begin
      vec_t       tbl[$];
      vec_t       v;
      logic [7:0] model;
      logic [7:0] d;
      int         start_cyc;

      tbl.push_back('{data:8'hA5, stop:1'b1, par_flip:1'b0, bit_clks:160, gap:60, exp_kind:K_READY, exp_data:8'hA5});
      tbl.push_back('{data:8'h00, stop:1'b1, par_flip:1'b0, bit_clks:160, gap:0,  exp_kind:K_READY, exp_data:8'h00});
      tbl.push_back('{data:8'hFF, stop:1'b1, par_flip:1'b0, bit_clks:160, gap:0,  exp_kind:K_READY, exp_data:8'hFF});
      tbl.push_back('{data:8'h55, stop:1'b1, par_flip:1'b0, bit_clks:160, gap:60, exp_kind:K_READY, exp_data:8'h55});
`ifdef UART_RX_PARITY_EN
      tbl.push_back('{data:8'h07, stop:1'b1, par_flip:1'b1, bit_clks:160, gap:60, exp_kind:K_PERR,  exp_data:8'h55});
`endif
      // Reference model: a frame with a low stop bit is a framing error, a bad
      // parity bit a parity error, otherwise the byte becomes the held data.
      model = tbl[tbl.size() - 1].exp_data;
      for (int i = 0; i < 14; i++) begin
         d          = 8'($urandom);
         v.data     = d;
         v.stop     = ($urandom_range(0, 4) != 0);
`ifdef UART_RX_PARITY_EN
         v.par_flip = ($urandom_range(0, 3) == 0);
`else
         v.par_flip = 1'b0;
`endif
         v.bit_clks = $urandom_range(156, 164);
         v.gap      = v.stop ? $urandom_range(0, 100) : $urandom_range(5, 100);
         if (!v.stop) v.exp_kind = K_FERR;
         else if (v.par_flip) v.exp_kind = K_PERR;
         else begin
            v.exp_kind = K_READY;
            model = d;
         end
         v.exp_data = model;
         tbl.push_back(v);
      end

      rst = 1'b1;
      RxD = 1'b1;
      #3 rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         RxD = ~RxD;
         repeat (3) @(negedge clk);
         checkOutput("reset_data", int'(RxD_data), 0);
         checkOutput("reset_ready", int'(RxD_data_ready), 0);
         checkOutput("reset_busy", int'(RxD_busy), 0);
         checkOutput("reset_ferr", int'(framing_err), 0);
         checkOutput("reset_perr", int'(parity_err), 0);
      end
      RxD = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      ev_q.delete();
      repeat (2000) @(negedge clk);
      checkOutput("idle_no_strobe", ev_q.size(), 0);
      checkOutput("idle_busy", int'(RxD_busy), 0);

      $display("[TB] applying %0d table vectors", tbl.size());
      for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i]);
      model = tbl[tbl.size() - 1].exp_data;

      $display("[TB] glitch sequence");
      ev_q.delete();
      holdLine(1'b0, 40);
      checkOutput("glitch_busy_on", int'(RxD_busy), 1);
      holdLine(1'b1, 60);
      checkOutput("glitch_busy_off", int'(RxD_busy), 0);
      holdLine(1'b1, 200);
      checkOutput("glitch_no_strobe", ev_q.size(), 0);

      $display("[TB] framing error with line held low");
      ev_q.delete();
      v = '{data:8'h3C, stop:1'b0, par_flip:1'b0, bit_clks:160, gap:0, exp_kind:K_FERR, exp_data:model};
      sendFrame(v, start_cyc);
      holdLine(1'b0, 2000);
      checkOutput("ferr_count", ev_q.size(), 1);
      if (ev_q.size() > 0) checkOutput("ferr_kind", ev_q[0].kind, K_FERR);
      checkOutput("ferr_data_kept", int'(RxD_data), int'(model));
      checkOutput("ferr_busy", int'(RxD_busy), 0);
      ev_q.delete();
      holdLine(1'b1, 100);
      checkOutput("ferr_quiet", ev_q.size(), 0);
      applyStimulus('{data:8'h5A, stop:1'b1, par_flip:1'b0, bit_clks:160, gap:40, exp_kind:K_READY, exp_data:8'h5A});

      $display("[TB] reset during bit 4");
      ev_q.delete();
      d = 8'hC3;
      holdLine(1'b0, 160);
      for (int i = 0; i < 4; i++) holdLine(d[i], 160);
      holdLine(d[4], 80);
      rst = 1'b0;
      holdLine(1'b1, 5);
      checkOutput("midreset_data", int'(RxD_data), 0);
      checkOutput("midreset_busy", int'(RxD_busy), 0);
      holdLine(1'b1, 100);
      rst = 1'b1;
      holdLine(1'b1, 2000);
      checkOutput("midreset_no_strobe", ev_q.size(), 0);
      checkOutput("midreset_data_after", int'(RxD_data), 0);

      $display("[TB] baud skew");
      applyStimulus('{data:8'hC3, stop:1'b1, par_flip:1'b0, bit_clks:155, gap:50, exp_kind:K_READY, exp_data:8'hC3});
      applyStimulus('{data:8'hC3, stop:1'b1, par_flip:1'b0, bit_clks:165, gap:50, exp_kind:K_READY, exp_data:8'hC3});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
